// File: rtl/duty_fade_sequencer.sv
// duty_fade_sequencer
//   Generates the duty-cycle command word for the PWM comparator as a
//   trapezoidal "breathing" profile: ramp up, hold high, ramp down, hold low,
//   repeat. Duty only changes on the PWM stage's period-boundary strobe so the
//   comparator never sees a mid-period update.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   enable       run the profile; low forces IDLE on the next clk
//   period_tick  one-cycle strobe at each PWM period wrap
//   duty         registered duty command (16 bits)
//   duty_valid   one-cycle pulse, visible together with a changed duty value
//   phase        state: IDLE=0 RAMP_UP=1 HOLD_HIGH=2 RAMP_DOWN=3 HOLD_LOW=4
//   fade_count   completed fade cycles, wraps 255 -> 0
module duty_fade_sequencer #(
  parameter int unsigned PWM_PERIOD   = 20000,
  parameter int unsigned DUTY_MIN     = 0,
  parameter int unsigned DUTY_MAX     = 14000,
  parameter int unsigned STEP         = 16,
  parameter int unsigned HOLD_PERIODS = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        period_tick,
  output logic [15:0] duty,
  output logic        duty_valid,
  output logic [2:0]  phase,
  output logic [7:0]  fade_count
);

  // Configuration legality, rejected at elaboration.
  if (!(DUTY_MIN < DUTY_MAX) || !(DUTY_MAX <= PWM_PERIOD) || (STEP == 0) ||
      (PWM_PERIOD >= 65536) || (STEP >= 65536) || (HOLD_PERIODS >= 65536)) begin : g_bad_cfg
    $error("duty_fade_sequencer: illegal parameter configuration");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  // Hold counter holds 0..HOLD_PERIODS-1; at least one bit even when holds are unused.
  localparam int unsigned HW        = (HOLD_PERIODS > 0) ? $clog2(HOLD_PERIODS + 1) : 1;
  localparam int unsigned HOLD_LAST = (HOLD_PERIODS > 0) ? HOLD_PERIODS - 1 : 0;

  localparam logic [15:0]   D_MIN  = 16'(DUTY_MIN);
  localparam logic [15:0]   D_MAX  = 16'(DUTY_MAX);
  localparam logic [15:0]   STEP_W = 16'(STEP);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_LAST);
  localparam logic          NO_HOLD  = (HOLD_PERIODS == 0);

  state_t        state;
  logic [HW-1:0] hold_cnt;

  // Headroom to each limit. duty is always within [D_MIN, D_MAX], so neither
  // difference can wrap, and no duty +/- STEP sum is ever formed before the test.
  logic [15:0] head_room;
  logic [15:0] foot_room;
  logic        up_sat;
  logic        down_sat;

  always_comb begin
    head_room = D_MAX - duty;
    foot_room = duty - D_MIN;
    up_sat    = !(head_room > STEP_W);
    down_sat  = !(foot_room > STEP_W);
  end

  assign phase = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty       <= D_MIN;
      duty_valid <= 1'b0;
      fade_count <= '0;
      hold_cnt   <= '0;
    end else begin
      duty_valid <= 1'b0;

      if (!enable) begin
        // Leaving an active state takes priority over a coincident tick:
        // duty is left untouched on that edge. Once idle, the next tick
        // parks duty at the minimum.
        if (state != IDLE) begin
          state    <= IDLE;
          hold_cnt <= '0;
        end else if (period_tick) begin
          duty       <= D_MIN;
          duty_valid <= (duty != D_MIN);
        end
      end else if (period_tick) begin
        unique case (state)
          IDLE: begin
            // Restart from the bottom of the profile; no step on this tick.
            state      <= RAMP_UP;
            hold_cnt   <= '0;
            duty       <= D_MIN;
            duty_valid <= (duty != D_MIN);
          end

          RAMP_UP: begin
            if (!up_sat) begin
              duty       <= duty + STEP_W;
              duty_valid <= 1'b1;
            end else begin
              duty       <= D_MAX;
              duty_valid <= (duty != D_MAX);
              hold_cnt   <= '0;
              state      <= NO_HOLD ? RAMP_DOWN : HOLD_HIGH;
            end
          end

          HOLD_HIGH: begin
            if (hold_cnt == HOLD_END) begin
              hold_cnt <= '0;
              state    <= RAMP_DOWN;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end

          RAMP_DOWN: begin
            if (!down_sat) begin
              duty       <= duty - STEP_W;
              duty_valid <= 1'b1;
            end else begin
              duty       <= D_MIN;
              duty_valid <= (duty != D_MIN);
              fade_count <= fade_count + 8'd1;
              hold_cnt   <= '0;
              state      <= NO_HOLD ? RAMP_UP : HOLD_LOW;
            end
          end

          HOLD_LOW: begin
            if (hold_cnt == HOLD_END) begin
              hold_cnt <= '0;
              state    <= RAMP_UP;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end

          default: begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_duty_fade_sequencer.sv
module tb_duty_fade_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DUTY_MIN=0, DUTY_MAX=100, STEP=30, HOLD_PERIODS=2
  logic        rst_n_a, enable_a, tick_a_r;
  logic [15:0] duty_a;
  logic        valid_a;
  logic [2:0]  phase_a;
  logic [7:0]  fade_a;

  // Instance B: DUTY_MIN=0, DUTY_MAX=100, STEP=100, HOLD_PERIODS=0
  logic        rst_n_b, enable_b, tick_b_r;
  logic [15:0] duty_b;
  logic        valid_b;
  logic [2:0]  phase_b;
  logic [7:0]  fade_b;

  duty_fade_sequencer #(
    .PWM_PERIOD  (20000),
    .DUTY_MIN    (0),
    .DUTY_MAX    (100),
    .STEP        (30),
    .HOLD_PERIODS(2)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n_a),
    .enable     (enable_a),
    .period_tick(tick_a_r),
    .duty       (duty_a),
    .duty_valid (valid_a),
    .phase      (phase_a),
    .fade_count (fade_a)
  );

  duty_fade_sequencer #(
    .PWM_PERIOD  (20000),
    .DUTY_MIN    (0),
    .DUTY_MAX    (100),
    .STEP        (100),
    .HOLD_PERIODS(0)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .enable     (enable_b),
    .period_tick(tick_b_r),
    .duty       (duty_b),
    .duty_valid (valid_b),
    .phase      (phase_b),
    .fade_count (fade_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Seven quiet clocks, then a one-cycle tick; returns just after the tick edge.
  task automatic tick_a();
    repeat (7) clk_step();
    tick_a_r = 1'b1;
    clk_step();
    tick_a_r = 1'b0;
  endtask

  task automatic check_a(input string tag, input int d, input int v, input int p);
    check({tag, ".duty"},  32'(duty_a),  32'(d));
    check({tag, ".valid"}, 32'(valid_a), 32'(v));
    check({tag, ".phase"}, 32'(phase_a), 32'(p));
  endtask

  logic [15:0] cont_exp [14] = '{16'd0, 16'd30, 16'd60, 16'd90, 16'd100, 16'd100, 16'd100,
                                 16'd70, 16'd40, 16'd10, 16'd0, 16'd0, 16'd0, 16'd30};

  initial begin
    rst_n_a  = 1'b0; enable_a = 1'b0; tick_a_r = 1'b0;
    rst_n_b  = 1'b0; enable_b = 1'b0; tick_b_r = 1'b0;
    clk_step();
    clk_step();
    rst_n_a = 1'b1;

    // Reset state
    check_a("reset", 0, 0, 0);
    check("reset.fade", 32'(fade_a), 0);

    // Ramp up
    enable_a = 1'b1;
    tick_a(); check_a("up_t1", 0, 0, 1);
    tick_a(); check_a("up_t2", 30, 1, 1);
    clk_step(); check("up_t2.valid_drop", 32'(valid_a), 0);
    tick_a(); check_a("up_t3", 60, 1, 1);
    tick_a(); check_a("up_t4", 90, 1, 1);
    tick_a(); check_a("up_t5", 100, 1, 2);

    // Hold high
    tick_a(); check_a("hh_t1", 100, 0, 2);
    tick_a(); check_a("hh_t2", 100, 0, 3);

    // Ramp down
    tick_a(); check_a("dn_t1", 70, 1, 3);
    tick_a(); check_a("dn_t2", 40, 1, 3);
    tick_a(); check_a("dn_t3", 10, 1, 3);
    check("dn_t3.fade", 32'(fade_a), 0);
    tick_a(); check_a("dn_t4", 0, 1, 4);
    check("dn_t4.fade", 32'(fade_a), 1);

    // Hold low then back to ramp up
    tick_a(); check_a("hl_t1", 0, 0, 4);
    tick_a(); check_a("hl_t2", 0, 0, 1);

    // Drop enable mid ramp at duty=60
    tick_a(); check_a("re_t1", 30, 1, 1);
    tick_a(); check_a("re_t2", 60, 1, 1);
    enable_a = 1'b0;
    clk_step(); check_a("dis_next", 60, 0, 0);
    repeat (3) clk_step();
    check_a("dis_hold", 60, 0, 0);
    tick_a(); check_a("dis_tick", 0, 1, 0);
    clk_step(); check("dis_tick.valid_drop", 32'(valid_a), 0);

    // Reset during HOLD_HIGH
    enable_a = 1'b1;
    tick_a(); check_a("rr_t1", 0, 0, 1);
    repeat (4) tick_a();
    check_a("rr_top", 100, 1, 2);
    tick_a(); check_a("rr_hold", 100, 0, 2);
    check("rr_hold.fade", 32'(fade_a), 1);
    rst_n_a = 1'b0;
    clk_step();
    rst_n_a = 1'b1;
    check_a("rr_after", 0, 0, 0);
    check("rr_after.fade", 32'(fade_a), 0);

    // Tick coincident with enable falling: enable wins, no step
    tick_a(); check_a("sim_t1", 0, 0, 1);
    tick_a(); check_a("sim_t2", 30, 1, 1);
    repeat (7) clk_step();
    tick_a_r = 1'b1;
    enable_a = 1'b0;
    clk_step();
    tick_a_r = 1'b0;
    check_a("sim_edge", 30, 0, 0);

    // Continuous ticks
    rst_n_a = 1'b0;
    clk_step();
    rst_n_a  = 1'b1;
    enable_a = 1'b1;
    tick_a_r = 1'b1;
    for (int i = 0; i < 14; i++) begin
      clk_step();
      check($sformatf("cont_%0d", i), 32'(duty_a), 32'(cont_exp[i]));
    end
    for (int i = 0; i < 30; i++) begin
      clk_step();
      check($sformatf("cont_range_%0d", i), 32'(duty_a <= 16'd100), 1);
    end
    tick_a_r = 1'b0;

    // No-hold build, full-swing step, tick every clk through a fade_count wrap
    rst_n_b = 1'b1;
    clk_step();
    check("b_reset.duty", 32'(duty_b), 0);
    enable_b = 1'b1;
    tick_b_r = 1'b1;
    for (int k = 1; k <= 513; k++) begin
      clk_step();
      check($sformatf("b_duty_%0d", k), 32'(duty_b), (k > 1 && k % 2 == 0) ? 32'd100 : 32'd0);
      check($sformatf("b_phase_%0d", k), 32'(phase_b), (k > 1 && k % 2 == 0) ? 32'd3 : 32'd1);
      if (k == 3)   check("b_fade_first", 32'(fade_b), 1);
      if (k == 511) check("b_fade_255", 32'(fade_b), 255);
      if (k == 513) check("b_fade_wrap", 32'(fade_b), 0);
    end
    tick_b_r = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/duty_fade_sequencer.md
Name: duty_fade_sequencer

Overview:
- Upstream companion of the PWM output stage: generates the duty-cycle command word that the PWM comparator consumes.
- Produces a trapezoidal "breathing" profile: ramp up, hold high, ramp down, hold low, repeat.
- Duty updates happen only on the PWM stage's period-boundary strobe, so the comparator never sees a mid-period duty change.
- Step size, limits and hold times are set by parameters, not hard-coded.

Parameters:
- PWM_PERIOD, 20000: counts per PWM period (25 MHz / 1.25 kHz); upper bound for DUTY_MAX.
- DUTY_MIN, 0: lowest duty issued; the reset value of duty.
- DUTY_MAX, 14000: highest duty issued (70 % of period).
- STEP, 16: duty increment/decrement per accepted period tick; must be >0.
- HOLD_PERIODS, 50: period ticks spent in each hold state; 0 = no hold.
- Legal configuration: DUTY_MIN < DUTY_MAX <= PWM_PERIOD, all values < 2^16. Elaboration-time check; other values are illegal.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: active-low reset, synchronous to clk.
- enable  in  1: run the profile; low forces the IDLE state.
- period_tick  in  1: one-cycle strobe from the PWM stage at each period wrap.
- duty  out  16: registered duty command to the PWM comparator.
- duty_valid  out  1: one-cycle pulse, the cycle after duty changes.
- phase  out  3: current state encoding (IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4).
- fade_count  out  8: number of completed fade cycles; wraps 255 -> 0.

Behaviour:
- Reset: rst_n sampled low at a posedge gives state IDLE, duty=DUTY_MIN, duty_valid=0, fade_count=0, hold counter=0.
  - Reset asserted mid-operation behaves identically; no partial step is kept.
- Latency: all state/duty updates occur on the posedge where period_tick=1. duty, phase and duty_valid are registered, so they are visible the following cycle.
- enable=0 in any state moves the block to IDLE on the next clk, without waiting for a tick. duty holds its value until the next period_tick, then loads DUTY_MIN; duty_valid pulses if the value changed.
- IDLE: on a tick with enable=1, move to RAMP_UP with no step applied on that tick.
- RAMP_UP, on each tick:
  - if DUTY_MAX - duty > STEP: duty += STEP.
  - else: duty = DUTY_MAX (saturate), and move to HOLD_HIGH, or straight to RAMP_DOWN if HOLD_PERIODS=0.
- HOLD_HIGH: count ticks; duty is unchanged. On the HOLD_PERIODS-th tick, clear the counter and move to RAMP_DOWN.
- RAMP_DOWN, on each tick:
  - if duty - DUTY_MIN > STEP: duty -= STEP.
  - else: duty = DUTY_MIN, fade_count += 1 on the same edge, and move to HOLD_LOW, or straight to RAMP_UP if HOLD_PERIODS=0.
- HOLD_LOW: mirror of HOLD_HIGH, then move to RAMP_UP.
- Arithmetic rules:
  - Comparisons are computed as differences against the limits, never as duty±STEP, so there is no 16-bit overflow or underflow.
  - duty is always within [DUTY_MIN, DUTY_MAX].
- duty_valid: high exactly one cycle following any tick edge that changed duty; low otherwise, including during holds.
- Simultaneous period_tick and enable falling: enable wins. State goes to IDLE and no step is applied that edge.
- Ticks on consecutive cycles are legal; each one is processed.
- Cycles without period_tick change nothing, except the enable=0 transition to IDLE.
- The hold counter is sized ceil(log2(HOLD_PERIODS+1)) bits and is cleared on every state entry.

Test Plan:
- Bench parameters for all scenarios: DUTY_MIN=0, DUTY_MAX=100, STEP=30, HOLD_PERIODS=2; tick every 8 clks.
- Reset then enable=1 -> tick1 gives phase=1, duty=0. Ticks 2-5 give duty 30, 60, 90, 100; phase=2 after tick5; duty_valid pulses 4 times.
- Continue -> 2 hold ticks, phase=3 after the 2nd. Next ticks give duty 70, 40, 10, 0; fade_count=1 and phase=4 after the 4th. 2 ticks later phase=1.
- enable dropped mid RAMP_UP at duty=60 -> phase=0 next clk, duty stays 60 until the next tick, then duty=0 with a single duty_valid pulse.
- rst_n low for 1 clk during HOLD_HIGH -> next cycle duty=0, phase=0, fade_count=0, duty_valid=0.
- Rebuild with HOLD_PERIODS=0, STEP=100 -> duty alternates 0/100 each tick after the first; phase never 2 or 4. Run 256 cycles and check fade_count wraps to 0.
- Drive period_tick high continuously with enable=1 -> duty steps every clk, stays within [0,100], no overflow.
